oclib_uart_cmd_parser: RTL and testbench
========================================

# oclib_uart_cmd_parser

Parses an ASCII command stream into 32-bit CSR read/write transactions and sends ASCII responses. It sits directly behind `oclib_uart`: it consumes received bytes and produces bytes to transmit over the same `oclib_pkg::bc_8b_bidi_s` channel. This gives a bring-up console with no processor in the design.

## Interface
- `TimeoutCycles`, default 1024: number of cycles a CSR request may stay outstanding before it is abandoned.
- `AddressWidth`, default 32: width of `csrAddress`. Only the low bits of the parsed 32-bit address are used.
- `clock` in 1: the single clock.
- `reset` in 1: asynchronous, active-high.
- `bcIn` in `bc_8b_bidi_s`:
  - `data`/`valid` carry the byte received from the UART.
  - `ready` means the UART accepts a transmit byte.
- `bcOut` out `bc_8b_bidi_s`:
  - `data`/`valid` carry the byte to transmit.
  - `ready` means this block accepts the received byte.
- `csrAddress` out `AddressWidth`: address of the transaction.
- `csrWdata` out 32: write data.
- `csrRead` out 1: read strobe, held until completion.
- `csrWrite` out 1: write strobe, held until completion.
- `csrRdata` in 32: read data, valid while `csrReady` is high.
- `csrReady` in 1: one-cycle completion pulse.
- `csrError` in 1: qualifies `csrReady`; high means the transaction failed.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- **States:** IDLE, ARG, FLUSH, EXEC, RESP.
- **Byte acceptance:** a received byte is accepted when `bcIn.valid && bcOut.ready`.
  - `bcOut.ready` is 1 in IDLE, ARG and FLUSH.
  - `bcOut.ready` is 0 in EXEC and RESP, which backpressures into the UART RX FIFO.
- **IDLE:**
  - CR, LF, space and tab are ignored.
  - `R`/`r` sets op=read and goes to ARG.
  - `W`/`w` sets op=write and goes to ARG.
  - Any other byte goes to FLUSH with err=syntax.
- **ARG:**
  - **Hex digit** (0-9, A-F, a-f):
    - acc = {acc[27:0], nibble}.
    - The digit count saturates at 8; extra digits shift out the MSBs.
  - **Space or tab:**
    - If digits>0, acc is stored into argument slot argCnt, argCnt increments, and acc and digits clear.
    - If digits=0 the byte is ignored.
  - **CR or LF:**
    - Any pending acc is pushed as above.
    - Read with argCnt=1 goes to EXEC.
    - Write with argCnt=2 goes to EXEC, with arg0 as the address and arg1 as the write data.
    - Any other argument count sends the error response and returns to IDLE.
  - **A third argument push, or any other byte**, goes to FLUSH with err=syntax.
- **FLUSH:** bytes are discarded until CR or LF. That byte is consumed, then the block goes to RESP with the error response.
- **EXEC:**
  - The strobe is asserted with the address and write data stable.
  - On `csrReady`:
    - The strobe drops in the same cycle the pulse is sampled.
    - `csrRdata` is captured and the block goes to RESP.
  - If `csrError` was high with `csrReady`, or the timeout counter reaches `TimeoutCycles`, the strobe drops and the block goes to RESP with err=csr.
- **Responses**, sent in RESP (uppercase hex, MSB nibble first):
  - Read: 8 hex digits, then CR, then LF.
  - Write: "OK", CR, LF.
  - Syntax error: "?", CR, LF.
  - CSR error or timeout: "!", CR, LF.
- **Transmit handshake:**
  - `bcOut.valid` holds with `bcOut.data` stable until `bcIn.ready`.
  - An index advances on each transfer.
  - After LF transfers, the block returns to IDLE and clears acc, digits, argCnt and err.

## Timing
- **Reset values:** `bcOut.valid`=0, `bcOut.ready`=0, `bcOut.data`=0, `csrRead`=0, `csrWrite`=0, `csrAddress`=0, `csrWdata`=0, `busy`=0, state=IDLE.
  - `bcOut.ready` rises on the first clock after reset deasserts.
- **Reset mid-operation:** strobes, `valid` and any partial response drop immediately on assertion. No resume.
- **Strobe timing:** the CSR strobe is asserted on the cycle after the terminating CR/LF is accepted.
- **Ready turnaround:**
  - `bcOut.ready` is 0 from the cycle after terminator acceptance.
  - It returns to 1 on the cycle after the final LF transfer.
- **Response start:** the first response byte is valid on the cycle after `csrReady`, or after the FLUSH terminator.
- **Transmit throughput:** one byte per cycle when `bcIn.ready` is held high.
- **Timeout:** the counter starts at strobe assertion. The error path fires at count=`TimeoutCycles`. If `csrReady` is sampled in that same cycle, the completion wins.
- **CR followed by LF:** the second terminator arrives in IDLE and is ignored.
- **Busy:** `busy`=1 in every state except IDLE.

## Structure
- Additions to `oclib_uart_pkg`:
  - ASCII constants (CR, LF, SP, TAB, '?', '!', 'O', 'K').
  - A state enum.
  - An error enum {none, syntax, csr}.
  - Functions `asciiToNibble`/`isHex` and `nibbleToAscii`.
- Single module; no sub-module. The hex conversion stays in the package functions.

## Test plan
- **Read:** "R 00000010\r" with `csrRdata`=0xDEADBEEF after 3 cycles.
  - `csrRead`=1 with `csrAddress`=0x10 until the `csrReady` pulse.
  - TX bytes are "DEADBEEF\r\n".
- **Write:** "w 4 a5\n".
  - `csrWrite`=1, `csrAddress`=0x4, `csrWdata`=0xA5.
  - TX "OK\r\n".
- **Syntax:** "R 1 2 3\r", "X12\n" and "W 10\r".
  - Each produces "?\r\n" and no strobe.
- **Timeout:** `TimeoutCycles`=16 and `csrReady` never arrives.
  - The strobe is held for exactly 16 cycles, then TX "!\r\n".
  - A `csrError`=1 completion also produces "!\r\n".
- **Backpressure:** `bcIn.ready` toggles randomly during a read response.
  - `bcOut.data` is stable while `valid`=1 and `ready`=0.
  - The byte sequence is unchanged.
  - `bcOut.ready`=0 for the whole EXEC/RESP span.
- **Async reset:** reset asserted mid-response, after 4 of 10 bytes.
  - All outputs are 0 in the same cycle.
  - A subsequent "R 0\r" works normally.

Source files
------------

// File: rtl/oclib_pkg.sv
// Shared oclib types: the byte-wide bidirectional stream channel used between
// the UART and its clients.
package oclib_pkg;

    typedef struct packed {
        logic [7:0] data;
        logic       valid;
        logic       ready;
    } bc_8b_bidi_s;

endpackage

// File: rtl/oclib_uart_pkg.sv
// UART console helpers: ASCII constants, command parser state/error enums and
// hex <-> ASCII conversion functions.
package oclib_uart_pkg;

    localparam logic [7:0] AsciiCr       = 8'h0d;
    localparam logic [7:0] AsciiLf       = 8'h0a;
    localparam logic [7:0] AsciiSp       = 8'h20;
    localparam logic [7:0] AsciiTab      = 8'h09;
    localparam logic [7:0] AsciiQuestion = 8'h3f;
    localparam logic [7:0] AsciiBang     = 8'h21;
    localparam logic [7:0] AsciiO        = 8'h4f;
    localparam logic [7:0] AsciiK        = 8'h4b;
    localparam logic [7:0] AsciiLowerR   = 8'h72;
    localparam logic [7:0] AsciiLowerW   = 8'h77;

    typedef enum logic [2:0] {StIdle, StArg, StFlush, StExec, StResp} cmd_state_e;
    typedef enum logic [1:0] {ErrNone, ErrSyntax, ErrCsr} cmd_err_e;

    function automatic logic isHex(input logic [7:0] c);
        return (c >= 8'h30 && c <= 8'h39) || (c >= 8'h41 && c <= 8'h46) ||
               (c >= 8'h61 && c <= 8'h66);
    endfunction

    // Letters: low nibble of 'A'/'a' is 1, so adding 9 yields 10..15.
    function automatic logic [3:0] asciiToNibble(input logic [7:0] c);
        return (c <= 8'h39) ? c[3:0] : c[3:0] + 4'd9;
    endfunction

    function automatic logic [7:0] nibbleToAscii(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
    endfunction

endpackage

// File: rtl/oclib_uart_cmd_parser.sv
// ASCII console: parses "R addr" / "W addr data" lines into CSR transactions
// and answers with hex read data, "OK", "?" (syntax) or "!" (CSR error/timeout).
module oclib_uart_cmd_parser
    import oclib_pkg::*;
    import oclib_uart_pkg::*;
#(
    parameter int TimeoutCycles = 1024,
    parameter int AddressWidth  = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  bc_8b_bidi_s             bcIn,
    output bc_8b_bidi_s             bcOut,
    output logic [AddressWidth-1:0] csrAddress,
    output logic [31:0]             csrWdata,
    output logic                    csrRead,
    output logic                    csrWrite,
    input  logic [31:0]             csrRdata,
    input  logic                    csrReady,
    input  logic                    csrError,
    output logic                    busy
);

    localparam int TimerW = $clog2(TimeoutCycles + 1);

    cmd_state_e        state, stateNext;
    cmd_err_e          err, errNext;
    logic              readyEn, opWrite;
    logic [31:0]       acc, arg0, arg1, rdataQ, addrSel, wdataSel, txShift;
    logic [3:0]        digits, txIdx;
    logic [1:0]        argCnt, cntAfter;
    logic [TimerW-1:0] timer;
    logic [7:0]        rxByte, txByte;
    logic              rxReady, rxFire, txFire, isWs, isTerm, isHexDigit;
    logic              isRead, isWrite, pending, cmdOk, lastByte, timeoutHit;

    always_comb begin
        rxByte     = bcIn.data;
        isWs       = (rxByte == AsciiSp) || (rxByte == AsciiTab);
        isTerm     = (rxByte == AsciiCr) || (rxByte == AsciiLf);
        isHexDigit = isHex(rxByte);
        // Setting bit 5 folds upper case onto lower case for the opcode letters.
        isRead     = (rxByte | 8'h20) == AsciiLowerR;
        isWrite    = (rxByte | 8'h20) == AsciiLowerW;
        pending    = digits != 4'd0;
        cntAfter   = argCnt + {1'b0, pending};
        cmdOk      = opWrite ? (cntAfter == 2'd2) : (cntAfter == 2'd1);
        addrSel    = (argCnt == 2'd0) ? acc : arg0;
        wdataSel   = (argCnt == 2'd1) ? acc : arg1;
        rxReady    = readyEn && (state == StIdle || state == StArg || state == StFlush);
        rxFire     = bcIn.valid && rxReady;
        txFire     = (state == StResp) && bcIn.ready;
        timeoutHit = timer == TimerW'(TimeoutCycles - 1);
        txShift    = rdataQ << {txIdx[2:0], 2'b00};

        txByte = AsciiLf;
        if (err != ErrNone) begin
            if (txIdx == 4'd0)      txByte = (err == ErrSyntax) ? AsciiQuestion : AsciiBang;
            else if (txIdx == 4'd1) txByte = AsciiCr;
        end else if (opWrite) begin
            if (txIdx == 4'd0)      txByte = AsciiO;
            else if (txIdx == 4'd1) txByte = AsciiK;
            else if (txIdx == 4'd2) txByte = AsciiCr;
        end else begin
            if (txIdx < 4'd8)       txByte = nibbleToAscii(txShift[31:28]);
            else if (txIdx == 4'd8) txByte = AsciiCr;
        end
        lastByte = txByte == AsciiLf;

        bcOut.data  = (state == StResp) ? txByte : 8'h00;
        bcOut.valid = state == StResp;
        bcOut.ready = rxReady;
        csrRead     = (state == StExec) && !opWrite;
        csrWrite    = (state == StExec) && opWrite;
        busy        = state != StIdle;
    end

    always_comb begin
        stateNext = state;
        errNext   = err;
        case (state)
            StIdle: begin
                if (rxFire && !isWs && !isTerm) begin
                    if (isRead || isWrite) begin
                        stateNext = StArg;
                    end else begin
                        stateNext = StFlush;
                        errNext   = ErrSyntax;
                    end
                end
            end
            StArg: begin
                if (rxFire) begin
                    if (isWs) begin
                        if (pending && argCnt == 2'd2) begin
                            stateNext = StFlush;
                            errNext   = ErrSyntax;
                        end
                    end else if (isTerm) begin
                        // The terminator is already consumed, so a bad count answers directly.
                        if (cmdOk) begin
                            stateNext = StExec;
                        end else begin
                            stateNext = StResp;
                            errNext   = ErrSyntax;
                        end
                    end else if (!isHexDigit) begin
                        stateNext = StFlush;
                        errNext   = ErrSyntax;
                    end
                end
            end
            StFlush: begin
                if (rxFire && isTerm) stateNext = StResp;
            end
            StExec: begin
                if (csrReady) begin
                    stateNext = StResp;
                    if (csrError) errNext = ErrCsr;
                end else if (timeoutHit) begin
                    stateNext = StResp;
                    errNext   = ErrCsr;
                end
            end
            StResp: begin
                if (txFire && lastByte) begin
                    stateNext = StIdle;
                    errNext   = ErrNone;
                end
            end
            default: stateNext = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= StIdle;
            err        <= ErrNone;
            readyEn    <= 1'b0;
            opWrite    <= 1'b0;
            acc        <= '0;
            digits     <= '0;
            argCnt     <= '0;
            arg0       <= '0;
            arg1       <= '0;
            rdataQ     <= '0;
            txIdx      <= '0;
            timer      <= '0;
            csrAddress <= '0;
            csrWdata   <= '0;
        end else begin
            state   <= stateNext;
            err     <= errNext;
            readyEn <= 1'b1;
            case (state)
                StIdle: begin
                    if (rxFire && (isRead || isWrite)) opWrite <= isWrite;
                end
                StArg: begin
                    if (rxFire) begin
                        if (isHexDigit) begin
                            acc <= {acc[27:0], asciiToNibble(rxByte)};
                            if (digits != 4'd8) digits <= digits + 4'd1;
                        end else if ((isWs || isTerm) && pending && argCnt != 2'd2) begin
                            if (argCnt == 2'd0) arg0 <= acc;
                            else                arg1 <= acc;
                            argCnt <= argCnt + 2'd1;
                            acc    <= '0;
                            digits <= '0;
                        end
                        if (isTerm && cmdOk) begin
                            csrAddress <= addrSel[AddressWidth-1:0];
                            if (opWrite) csrWdata <= wdataSel;
                            timer <= '0;
                        end
                    end
                end
                StExec: begin
                    timer <= timer + TimerW'(1);
                    if (csrReady && !csrError) rdataQ <= csrRdata;
                end
                StResp: begin
                    if (txFire) begin
                        if (lastByte) begin
                            txIdx  <= '0;
                            acc    <= '0;
                            digits <= '0;
                            argCnt <= '0;
                        end else begin
                            txIdx <= txIdx + 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_oclib_uart_cmd_parser.sv
// Bench for oclib_uart_cmd_parser: table of command lines with expected CSR
// activity and ASCII responses, plus reset and mid-response reset sequences.
module tb_oclib_uart_cmd_parser;
    import oclib_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic [7:0]  rxData = 8'h00;
    logic        rxValid = 1'b0;
    logic        txReady = 1'b1;
    bc_8b_bidi_s bcIn, bcOut;
    assign bcIn = '{data: rxData, valid: rxValid, ready: txReady};

    logic [31:0] csrAddress, csrWdata;
    logic [31:0] csrRdata = 32'h0;
    logic        csrRead, csrWrite, busy;
    logic        csrReady = 1'b0;
    logic        csrError = 1'b0;

    oclib_uart_cmd_parser #(.TimeoutCycles(16), .AddressWidth(32)) dut (
        .clock(clk), .reset(rst), .bcIn(bcIn), .bcOut(bcOut),
        .csrAddress(csrAddress), .csrWdata(csrWdata), .csrRead(csrRead),
        .csrWrite(csrWrite), .csrRdata(csrRdata), .csrReady(csrReady),
        .csrError(csrError), .busy(busy)
    );

    // Stimulus controls, written only by the main initial block.
    int          respDelay = 0;
    logic [31:0] respData = 32'h0;
    logic        respErr = 1'b0;
    logic        respEnable = 1'b0;
    logic        bpMode = 1'b0;

    // Monitor state, written only by the negedge monitor.
    int          strobeCnt = 0, readCycles = 0, writeCycles = 0, validCycles = 0;
    int          holdViol = 0, readyViol = 0, stableViol = 0;
    logic [31:0] seenAddr = 32'h0, seenWdata = 32'h0;
    logic        prevHold = 1'b0;
    logic [7:0]  prevData = 8'h00;
    logic [7:0]  txq[$];

    int passed = 0, total = 0;

    always begin
        @(posedge clk);
        #1;
        txReady = bpMode ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    // CSR responder plus protocol monitors, all sampled mid-cycle.
    always @(negedge clk) begin
        csrReady = 1'b0;
        csrError = 1'b0;
        if (rst) begin
            strobeCnt = 0;
            prevHold  = 1'b0;
        end else begin
            if (csrRead || csrWrite) begin
                if (strobeCnt == 0) begin
                    seenAddr  = csrAddress;
                    seenWdata = csrWdata;
                end else if (csrAddress != seenAddr || csrWdata != seenWdata) begin
                    stableViol++;
                end
                strobeCnt++;
                if (csrRead)  readCycles++;
                if (csrWrite) writeCycles++;
                if (bcOut.ready) readyViol++;
                if (respEnable && strobeCnt == respDelay) begin
                    csrReady = 1'b1;
                    csrError = respErr;
                    csrRdata = respData;
                end
            end else begin
                strobeCnt = 0;
            end
            if (bcOut.valid) begin
                validCycles++;
                if (bcOut.ready) readyViol++;
                if (prevHold && bcOut.data != prevData) holdViol++;
                if (bcIn.ready) txq.push_back(bcOut.data);
                prevHold = !bcIn.ready;
                prevData = bcOut.data;
            end else begin
                prevHold = 1'b0;
            end
        end
    end

    typedef struct {
        string       cmd;
        int          delay;
        logic [31:0] rdata;
        logic        cerr;
        logic        bp;
        logic        expRead;
        logic        expWrite;
        int          expCycles;
        logic [31:0] expAddr;
        logic [31:0] expWdata;
        string       expResp;
    } vec_t;

    function automatic vec_t mk(string cmd, int delay, logic [31:0] rdata, logic cerr,
                                logic bp, logic er, logic ew, int cyc,
                                logic [31:0] addr, logic [31:0] wd, string resp);
        vec_t v;
        v.cmd = cmd; v.delay = delay; v.rdata = rdata; v.cerr = cerr; v.bp = bp;
        v.expRead = er; v.expWrite = ew; v.expCycles = cyc; v.expAddr = addr;
        v.expWdata = wd; v.expResp = resp;
        return v;
    endfunction

    function automatic string vis(string s);
        string r = "";
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] == 8'h0d)      r = {r, "<CR>"};
            else if (s[i] == 8'h0a) r = {r, "<LF>"};
            else                    r = {r, $sformatf("%c", s[i])};
        end
        return r;
    endfunction

    function automatic string collected(int start);
        string r = "";
        for (int i = start; i < txq.size(); i++) r = {r, $sformatf("%c", txq[i])};
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    endtask

    task automatic check_str(input string name, input string act, input string exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got \"%s\", want \"%s\"", name, vis(act), vis(exp));
    endtask

    task automatic bound_fail(input string name);
        total++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic send_byte(input logic [7:0] c);
        int n = 0;
        rxData  = c;
        rxValid = 1'b1;
        while (!bcOut.ready && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 300) bound_fail("rx accept");
        @(negedge clk);
        #1;
        rxValid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic wait_resp(input int start);
        int n = 0;
        while (!(txq.size() > start && txq[txq.size()-1] == 8'h0a) && n < 3000) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 3000) bound_fail("response LF");
        @(negedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int r0, w0, v0, start;
        respData   = v.rdata;
        respErr    = v.cerr;
        respDelay  = v.delay;
        respEnable = v.delay != 0;
        bpMode     = v.bp;
        r0 = readCycles; w0 = writeCycles; v0 = validCycles; start = txq.size();
        send_str(v.cmd);
        wait_resp(start);
        bpMode = 1'b0;
        check_str({tag, " resp"}, collected(start), v.expResp);
        check({tag, " read cycles"}, 32'(readCycles - r0), v.expRead ? 32'(v.expCycles) : 32'h0);
        check({tag, " write cycles"}, 32'(writeCycles - w0), v.expWrite ? 32'(v.expCycles) : 32'h0);
        if (v.expCycles != 0) check({tag, " addr"}, seenAddr, v.expAddr);
        if (v.expWrite) check({tag, " wdata"}, seenWdata, v.expWdata);
        if (!v.bp) check({tag, " tx cycles"}, 32'(validCycles - v0), 32'(v.expResp.len()));
        check({tag, " idle after"}, {31'h0, busy}, 32'h0);
    endtask

    vec_t vecs[10];

    initial begin
        int start, n;
        vecs[0] = mk("R 00000010\015", 3, 32'hDEADBEEF, 0, 1, 1, 0, 3, 32'h10, 0, "DEADBEEF\015\n");
        vecs[1] = mk("w 4 a5\n", 2, 32'h0, 0, 0, 0, 1, 2, 32'h4, 32'hA5, "OK\015\n");
        vecs[2] = mk("R 1 2 3\015", 1, 32'h0, 0, 0, 0, 0, 0, 0, 0, "?\015\n");
        vecs[3] = mk("X12\n", 1, 32'h0, 0, 0, 0, 0, 0, 0, 0, "?\015\n");
        vecs[4] = mk("W 10\015", 1, 32'h0, 0, 0, 0, 0, 0, 0, 0, "?\015\n");
        vecs[5] = mk("r 20\015", 0, 32'h0, 0, 0, 1, 0, 16, 32'h20, 0, "!\015\n");
        vecs[6] = mk("W 8 1\015", 1, 32'h0, 1, 0, 0, 1, 1, 32'h8, 32'h1, "!\015\n");
        vecs[7] = mk("R 123456789\015", 1, 32'h0000ABCD, 0, 1, 1, 0, 1, 32'h23456789, 0, "0000ABCD\015\n");
        vecs[8] = mk("  r\t1f \015", 5, 32'h12345678, 0, 0, 1, 0, 5, 32'h1F, 0, "12345678\015\n");
        vecs[9] = mk("R 4\015\n", 1, 32'h00000000, 0, 0, 1, 0, 1, 32'h4, 0, "00000000\015\n");

        repeat (2) @(negedge clk);
        #1;
        check("reset bcOut", 32'(bcOut), 32'h0);
        check("reset strobes/busy", {29'h0, csrRead, csrWrite, busy}, 32'h0);
        check("reset addr", csrAddress, 32'h0);
        check("reset wdata", csrWdata, 32'h0);
        rst = 1'b0;
        #1;
        check("ready before first clock", {31'h0, bcOut.ready}, 32'h0);
        @(negedge clk);
        #1;
        check("ready after first clock", {31'h0, bcOut.ready}, 32'h1);

        for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset mid-response after 4 of 10 bytes, then a fresh read.
        respData = 32'hCAFEF00D; respErr = 1'b0; respDelay = 1; respEnable = 1'b1;
        start = txq.size();
        send_str("R 10\015");
        n = 0;
        while (txq.size() - start < 4 && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 500) bound_fail("mid-response bytes");
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midreset bcOut", 32'(bcOut), 32'h0);
        check("midreset strobes/busy", {29'h0, csrRead, csrWrite, busy}, 32'h0);
        check("midreset addr", csrAddress, 32'h0);
        check("midreset wdata", csrWdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midreset bytes sent", 32'(txq.size() - start), 32'h4);
        run_vec(mk("R 0\015", 2, 32'h00C0FFEE, 0, 0, 1, 0, 2, 32'h0, 0, "00C0FFEE\015\n"), "post-reset");

        check("tx data held under backpressure", 32'(holdViol), 32'h0);
        check("rx ready low in EXEC/RESP", 32'(readyViol), 32'h0);
        check("csr addr/wdata stable", 32'(stableViol), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
